// File: rtl/i2s_frame_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_frame_receiver_pkg
//  Description : Shared constants for the I2S frame receiver: default sample
//                width, word-select polarity and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_frame_receiver_pkg;

    // Default sample width and matching bit-counter width
    localparam int c_WIDTH_DEFAULT     = 24;
    localparam int c_CNT_WIDTH_DEFAULT = 5;

    // Word-select polarity
    localparam logic c_WS_LEFT  = 1'b0;
    localparam logic c_WS_RIGHT = 1'b1;

    // Frame-sync FSM encoding
    localparam logic [1:0] c_ST_UNSYNC = 2'd0;
    localparam logic [1:0] c_ST_LEFT   = 2'd1;
    localparam logic [1:0] c_ST_RIGHT  = 2'd2;

endpackage : i2s_frame_receiver_pkg
`default_nettype wire

// File: rtl/i2s_word_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_word_shifter
//  Description : Left-aligned MSB-first word assembler. Inserts one serial bit
//                per clock at position WIDTH-1-count, saturates once WIDTH
//                bits are held, and clears on close. The word output already
//                includes the bit presented this cycle, so a word can be
//                captured on the same cycle that closes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_word_shifter
    import i2s_frame_receiver_pkg::*;
#(
    parameter int WIDTH     = c_WIDTH_DEFAULT,
    parameter int CNT_WIDTH = c_CNT_WIDTH_DEFAULT
) (
    input  logic             sck,
    input  logic             reset,
    input  logic             sd,
    input  logic             close,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0]     r_shreg;
    logic [CNT_WIDTH-1:0] r_count;
    logic [WIDTH-1:0]     w_word;

    // Insert the current bit at its left-aligned slot; a saturated count matches no slot
    always_comb begin
        w_word = r_shreg;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_count == CNT_WIDTH'(WIDTH - 1 - i)) begin
                w_word[i] = sd;
            end
        end
    end

    // Keep the partial word and bit count; closing starts a fresh, zeroed word
    always_ff @(posedge sck) begin
        if (reset || close) begin
            r_shreg <= '0;
            r_count <= '0;
        end else begin
            r_shreg <= w_word;
            if (r_count < CNT_WIDTH'(WIDTH)) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    assign word = w_word;

endmodule : i2s_word_shifter
`default_nettype wire

// File: rtl/i2s_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_frame_receiver
//  Description : Deserialises an I2S stream into left/right sample pairs and
//                presents each completed stereo frame on a valid/ready port.
//                Tracks frame alignment and flags dropped frames (sticky).
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_frame_receiver
    import i2s_frame_receiver_pkg::*;
#(
    parameter int WIDTH     = c_WIDTH_DEFAULT,
    parameter int CNT_WIDTH = c_CNT_WIDTH_DEFAULT
) (
    input  logic             sck,
    input  logic             reset,
    input  logic             ws,
    input  logic             sd,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] frame_left,
    output logic [WIDTH-1:0] frame_right,
    output logic             overrun,
    output logic             synced
);

    logic             r_ws_d;
    logic             w_ws_edge;
    logic             w_fall;
    logic             w_rise;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             w_synced;
    logic             w_latch_left;
    logic             w_emit;

    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_left_hold;

    logic             r_valid;
    logic             r_overrun;
    logic [WIDTH-1:0] r_frame_left;
    logic [WIDTH-1:0] r_frame_right;

    // Delayed word select for edge detection
    always_ff @(posedge sck) begin
        if (reset) begin
            r_ws_d <= 1'b0;
        end else begin
            r_ws_d <= ws;
        end
    end

    assign w_ws_edge = ws ^ r_ws_d;
    assign w_fall    = (r_ws_d == c_WS_RIGHT) && (ws == c_WS_LEFT);
    assign w_rise    = (r_ws_d == c_WS_LEFT)  && (ws == c_WS_RIGHT);

    // One shifter serves both channels; every ws edge closes the current word
    i2s_word_shifter #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_shifter (
        .sck   (sck),
        .reset (reset),
        .sd    (sd),
        .close (w_ws_edge),
        .word  (w_word)
    );

    // FSM state register
    always_ff @(posedge sck) begin
        if (reset) begin
            r_state <= c_ST_UNSYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: only a fall edge can establish alignment
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_UNSYNC: if (w_fall) w_state_next = c_ST_LEFT;
            c_ST_LEFT:   if (w_rise) w_state_next = c_ST_RIGHT;
            c_ST_RIGHT:  if (w_fall) w_state_next = c_ST_LEFT;
            default:     w_state_next = c_ST_UNSYNC;
        endcase
    end

    // FSM outputs: alignment flag, left-word capture and frame completion
    always_comb begin
        w_synced     = 1'b0;
        w_latch_left = 1'b0;
        w_emit       = 1'b0;
        case (r_state)
            c_ST_LEFT: begin
                w_synced     = 1'b1;
                w_latch_left = w_rise;
            end
            c_ST_RIGHT: begin
                w_synced = 1'b1;
                w_emit   = w_fall;
            end
            default: begin
                w_synced = 1'b0;
            end
        endcase
    end

    // Hold the finished left word until its right partner completes
    always_ff @(posedge sck) begin
        if (reset) begin
            r_left_hold <= '0;
        end else if (w_latch_left) begin
            r_left_hold <= w_word;
        end
    end

    // Output buffer: load on emit when free or being consumed, else drop and flag
    always_ff @(posedge sck) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_left  <= '0;
            r_frame_right <= '0;
        end else if (w_emit) begin
            if (!r_valid || ready) begin
                r_valid       <= 1'b1;
                r_frame_left  <= r_left_hold;
                r_frame_right <= w_word;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    assign valid       = r_valid;
    assign overrun     = r_overrun;
    assign frame_left  = r_frame_left;
    assign frame_right = r_frame_right;
    assign synced      = w_synced;

endmodule : i2s_frame_receiver
`default_nettype wire
